// File: rtl/cep_tx_sched_pkg.sv
// Shared types and constants for the CEP transmit scheduler.
// State encodings, source identifiers and link-level widths.
package cep_tx_sched_pkg;

  localparam int CEP_DATA_WIDTH   = 64;
  localparam int CEP_CREDIT_WIDTH = 8;

  typedef enum logic [1:0] {
    CEP_TXS_IDLE      = 2'd0,
    CEP_TXS_LOCK_REQ  = 2'd1,
    CEP_TXS_LOCK_RESP = 2'd2
  } txs_state_e;

  typedef enum logic {
    SRC_REQ  = 1'b0,
    SRC_RESP = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    other_src = (s == SRC_REQ) ? SRC_RESP : SRC_REQ;
  endfunction

endpackage

// File: rtl/cep_tx_sched_if.sv
// Beat handshake bundle: valid/data/last travel with the beat, rdy flows back.
interface cep_tx_sched_if
  import cep_tx_sched_pkg::*;
#(
  parameter int DW = CEP_DATA_WIDTH
) ();

  logic          val;
  logic [DW-1:0] data;
  logic          last;
  logic          rdy;

  modport master (output val, output data, output last, input rdy);
  modport slave  (input val, input data, input last, output rdy);

endinterface

// File: rtl/cep_tx_sched_credit.sv
// Link credit counter: one credit per beat sent, one per far-end slot freed.
// Returns beyond the link buffer depth saturate and raise a sticky error.
module cep_credit_counter
  import cep_tx_sched_pkg::*;
#(
  parameter int CREDITS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic                        return_i,
  output logic [CEP_CREDIT_WIDTH-1:0] credits_o,
  output logic                        credit_err_o
);

  localparam logic [CEP_CREDIT_WIDTH-1:0] CREDITS_C = CEP_CREDIT_WIDTH'(CREDITS);

  logic [CEP_CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic                        err_q, err_d;

  // Next credit count and sticky overflow flag.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    case ({load_i, return_i})
      2'b10: credits_d = credits_q - 8'd1;
      2'b01: begin
        if (credits_q == CREDITS_C) begin
          err_d = 1'b1;
        end else begin
          credits_d = credits_q + 8'd1;
        end
      end
      default: credits_d = credits_q;
    endcase
  end

  // Counter and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CREDITS_C;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign credits_o    = credits_q;
  assign credit_err_o = err_q;

endmodule

// File: rtl/cep_tx_sched.sv
// CEP transmit scheduler: message-atomic round-robin between request and
// response sources into a one-entry output stage under link credit control.
module cep_tx_sched
  import cep_tx_sched_pkg::*;
#(
  parameter int CREDITS = 8,
  parameter int DW      = CEP_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  cep_tx_sched_if.slave               req_if,
  cep_tx_sched_if.slave               resp_if,
  cep_tx_sched_if.master              out_if,
  input  logic                        credit_return_i,
  output logic [CEP_CREDIT_WIDTH-1:0] credits_o,
  output logic                        busy_o,
  output logic                        credit_err_o
);

  txs_state_e    state_q, state_d;
  src_e          prio_q, prio_d;
  logic          out_val_q, out_val_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic [CEP_CREDIT_WIDTH-1:0] credits_s;
  logic          can_load_s;
  logic          gnt_req_s, gnt_resp_s;
  logic          req_hs_s, resp_hs_s, load_s;

  assign can_load_s = (~out_val_q | out_if.rdy) & (credits_s != 8'd0);
  assign req_hs_s   = req_if.val & req_if.rdy;
  assign resp_hs_s  = resp_if.val & resp_if.rdy;
  assign load_s     = req_hs_s | resp_hs_s;

  // State and priority registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CEP_TXS_IDLE;
      prio_q  <= SRC_REQ;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Next state: lock on a non-final beat, release and rotate priority on the last.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      CEP_TXS_IDLE: begin
        if (req_hs_s) begin
          if (req_if.last) begin
            prio_d = other_src(SRC_REQ);
          end else begin
            state_d = CEP_TXS_LOCK_REQ;
          end
        end else if (resp_hs_s) begin
          if (resp_if.last) begin
            prio_d = other_src(SRC_RESP);
          end else begin
            state_d = CEP_TXS_LOCK_RESP;
          end
        end else begin
          state_d = CEP_TXS_IDLE;
        end
      end
      CEP_TXS_LOCK_REQ: begin
        if (req_hs_s && req_if.last) begin
          state_d = CEP_TXS_IDLE;
          prio_d  = other_src(SRC_REQ);
        end else begin
          state_d = CEP_TXS_LOCK_REQ;
        end
      end
      CEP_TXS_LOCK_RESP: begin
        if (resp_hs_s && resp_if.last) begin
          state_d = CEP_TXS_IDLE;
          prio_d  = other_src(SRC_RESP);
        end else begin
          state_d = CEP_TXS_LOCK_RESP;
        end
      end
      default: begin
        state_d = CEP_TXS_IDLE;
        prio_d  = SRC_REQ;
      end
    endcase
  end

  // Grant and ready: a locked state serves only its owner; held low during reset.
  always_comb begin
    gnt_req_s  = 1'b0;
    gnt_resp_s = 1'b0;
    case (state_q)
      CEP_TXS_IDLE: begin
        if (req_if.val && (!resp_if.val || prio_q == SRC_REQ)) begin
          gnt_req_s = 1'b1;
        end else if (resp_if.val) begin
          gnt_resp_s = 1'b1;
        end else begin
          gnt_req_s  = 1'b0;
          gnt_resp_s = 1'b0;
        end
      end
      CEP_TXS_LOCK_REQ:  gnt_req_s  = 1'b1;
      CEP_TXS_LOCK_RESP: gnt_resp_s = 1'b1;
      default: begin
        gnt_req_s  = 1'b0;
        gnt_resp_s = 1'b0;
      end
    endcase
    req_if.rdy  = gnt_req_s  & can_load_s & ~rst;
    resp_if.rdy = gnt_resp_s & can_load_s & ~rst;
  end

  // Output stage: load the accepted beat, otherwise drain when the link takes it.
  always_comb begin
    out_val_d  = out_val_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    if (req_hs_s) begin
      out_val_d  = 1'b1;
      out_data_d = req_if.data;
      out_last_d = req_if.last;
    end else if (resp_hs_s) begin
      out_val_d  = 1'b1;
      out_data_d = resp_if.data;
      out_last_d = resp_if.last;
    end else if (out_if.rdy) begin
      out_val_d = 1'b0;
    end else begin
      out_val_d = out_val_q;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      out_val_q  <= out_val_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  cep_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load_s),
    .return_i     (credit_return_i),
    .credits_o    (credits_s),
    .credit_err_o (credit_err_o)
  );

  assign out_if.val  = out_val_q;
  assign out_if.data = out_data_q;
  assign out_if.last = out_last_q;
  assign credits_o   = credits_s;
  assign busy_o      = (state_q != CEP_TXS_IDLE) | out_val_q;

endmodule

// File: tb/tb_cep_tx_sched.sv
// Scoreboard bench for cep_tx_sched: directed stimulus pushes expected beats,
// a link-side monitor pops and compares every beat the link accepts.
module tb_cep_tx_sched;
  import cep_tx_sched_pkg::*;

  localparam int DW   = 64;
  localparam int CRED = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       credit_return;
  logic [7:0] credits;
  logic       busy, credit_err;

  cep_tx_sched_if #(.DW(DW)) req_if ();
  cep_tx_sched_if #(.DW(DW)) resp_if ();
  cep_tx_sched_if #(.DW(DW)) out_if ();

  cep_tx_sched #(.CREDITS(CRED), .DW(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_if          (req_if),
    .resp_if         (resp_if),
    .out_if          (out_if),
    .credit_return_i (credit_return),
    .credits_o       (credits),
    .busy_o          (busy),
    .credit_err_o    (credit_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded); returns at edge+1.
  task automatic send(input bit sel, input logic [DW-1:0] d, input logic l);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    if (!sel) begin
      req_if.val = 1'b1; req_if.data = d; req_if.last = l;
    end else begin
      resp_if.val = 1'b1; resp_if.data = d; resp_if.last = l;
    end
    while (!hs && n < 40) begin
      @(negedge clk);
      hs = sel ? resp_if.rdy : req_if.rdy;
      n++;
      step();
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL send_timeout sel=%0d actual=no_accept required=accept data=%h", sel, d);
    end
    if (!sel) req_if.val = 1'b0;
    else      resp_if.val = 1'b0;
  endtask

  task automatic give_back(input int n);
    for (int i = 0; i < n; i++) begin
      credit_return = 1'b1;
      step();
    end
    credit_return = 1'b0;
  endtask

  // Link-side monitor: every accepted output beat must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_if.val && out_if.rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=%h required=none", out_if.data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (out_if.data !== e) begin
          errors++;
          $display("FAIL sb_data actual=%h required=%h", out_if.data, e);
        end
      end
    end
  end

  initial begin
    req_if.val = 1'b0;  req_if.data = '0;  req_if.last = 1'b0;
    resp_if.val = 1'b0; resp_if.data = '0; resp_if.last = 1'b0;
    out_if.rdy = 1'b1;
    credit_return = 1'b0;

    // Reset state, with a request already offered
    req_if.val = 1'b1;
    #12;
    chk("rst_req_rdy", 64'(req_if.rdy), 64'd0);
    chk("rst_out_val", 64'(out_if.val), 64'd0);
    chk("rst_out_data", out_if.data, 64'd0);
    chk("rst_credits", 64'(credits), 64'd8);
    chk("rst_err", 64'(credit_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    req_if.val = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Single beat: accepted on cycle 0, visible on cycle 1
    exp_q.push_back(64'hA5A5_A5A5_A5A5_A5A5);
    req_if.val = 1'b1; req_if.data = 64'hA5A5_A5A5_A5A5_A5A5; req_if.last = 1'b1;
    @(negedge clk);
    chk("single_rdy", 64'(req_if.rdy), 64'd1);
    step();
    req_if.val = 1'b0;
    @(negedge clk);
    chk("single_out_val", 64'(out_if.val), 64'd1);
    chk("single_out_data", out_if.data, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("single_credits", 64'(credits), 64'd7);
    @(negedge clk);
    chk("single_idle", 64'(busy), 64'd0);
    step();
    give_back(1);

    // Round-robin from a fresh reset: REQ first, then alternate
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(64'h1000 + 64'(i));
      exp_q.push_back(64'h2000 + 64'(i));
    end
    fork
      for (int i = 0; i < 3; i++) send(1'b0, 64'h1000 + 64'(i), 1'b1);
      for (int j = 0; j < 3; j++) send(1'b1, 64'h2000 + 64'(j), 1'b1);
    join
    give_back(6);
    @(negedge clk);
    chk("rr_credits_restored", 64'(credits), 64'd8);
    step();

    // Message atomicity: 3-beat request vs. waiting 1-beat response
    exp_q.push_back(64'h3000); exp_q.push_back(64'h3001);
    exp_q.push_back(64'h3002); exp_q.push_back(64'h4000);
    fork
      begin
        send(1'b0, 64'h3000, 1'b0);
        send(1'b0, 64'h3001, 1'b0);
        send(1'b0, 64'h3002, 1'b1);
      end
      send(1'b1, 64'h4000, 1'b1);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("atomic_resp_rdy_low", 64'(resp_if.rdy), 64'd0);
      end
    join
    give_back(4);

    // Backpressure: held output, blocked second beat, credits unchanged
    out_if.rdy = 1'b0;
    exp_q.push_back(64'h5000); exp_q.push_back(64'h5001);
    send(1'b0, 64'h5000, 1'b1);
    req_if.val = 1'b1; req_if.data = 64'h5001; req_if.last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_data", out_if.data, 64'h5000);
      chk("bp_req_rdy", 64'(req_if.rdy), 64'd0);
      chk("bp_credits", 64'(credits), 64'd7);
    end
    step();
    out_if.rdy = 1'b1;
    send(1'b0, 64'h5001, 1'b1);
    give_back(2);

    // Credit exhaustion, then exactly one beat per returned credit
    for (int i = 0; i < 9; i++) exp_q.push_back(64'h6000 + 64'(i));
    for (int i = 0; i < 8; i++) send(1'b0, 64'h6000 + 64'(i), 1'b1);
    req_if.val = 1'b1; req_if.data = 64'h6008; req_if.last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("exh_rdy_low", 64'(req_if.rdy), 64'd0);
      chk("exh_credits0", 64'(credits), 64'd0);
    end
    step();
    credit_return = 1'b1;
    @(negedge clk);
    chk("exh_rdy_during_return", 64'(req_if.rdy), 64'd0);
    step();
    credit_return = 1'b0;
    @(negedge clk);
    chk("exh_rdy_after_return", 64'(req_if.rdy), 64'd1);
    chk("exh_credits1", 64'(credits), 64'd1);
    step();
    req_if.data = 64'h6009;
    @(negedge clk);
    chk("exh_one_only", 64'(req_if.rdy), 64'd0);
    chk("exh_credits_back0", 64'(credits), 64'd0);
    step();
    req_if.val = 1'b0;

    // Overflow: refill to CREDITS, then one return too many
    give_back(8);
    @(negedge clk);
    chk("ovf_full", 64'(credits), 64'd8);
    chk("ovf_err_before", 64'(credit_err), 64'd0);
    step();
    give_back(1);
    @(negedge clk);
    chk("ovf_err_set", 64'(credit_err), 64'd1);
    chk("ovf_credits_hold", 64'(credits), 64'd8);
    step();

    // Reset in LOCK_RESP with a beat stuck in the output stage
    out_if.rdy = 1'b0;
    send(1'b1, 64'h7000, 1'b0);
    resp_if.val = 1'b1; resp_if.data = 64'h7001; resp_if.last = 1'b1;
    @(negedge clk);
    chk("lock_busy", 64'(busy), 64'd1);
    chk("lock_credits", 64'(credits), 64'd7);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_val", 64'(out_if.val), 64'd0);
    chk("mid_rst_credits", 64'(credits), 64'd8);
    chk("mid_rst_err", 64'(credit_err), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_resp_rdy", 64'(resp_if.rdy), 64'd0);
    resp_if.val = 1'b0;
    step();
    rst = 1'b0;
    out_if.rdy = 1'b1;
    exp_q.push_back(64'h7100);
    send(1'b0, 64'h7100, 1'b1);

    repeat (4) step();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
